sdram_arbit: RTL and testbench
==============================

Name: sdram_arbit

Overview:
- Sits directly downstream of the SDRAM init, auto-refresh, write and read stages.
- Grants the shared SDRAM command/address bus to one stage at a time and drives the SDRAM pins.
- Owns the bidirectional DQ tri-state buffer.
- Priority: auto-refresh over write/read; write and read alternate round-robin when both request.

Parameters:
- BA_W, 2, bank address width
- ADDR_W, 13, row/column address bus width
- DQ_W, 16, SDRAM data width

Ports:
- i_sysclk  in  1  system clock (SDRAM clock domain)
- i_sysrst_n  in  1  reset
- i_init_cmd  in  4  init stage command {CS_N,RAS_N,CAS_N,WE_N}
- i_init_ba  in  BA_W  init stage bank
- i_init_addr  in  ADDR_W  init stage address
- i_init_done  in  1  init complete; sticky high
- i_aref_req  in  1  refresh request, level, held until serviced
- i_aref_cmd / i_aref_ba / i_aref_addr  in  4/BA_W/ADDR_W  refresh stage bus
- i_aref_done  in  1  refresh complete pulse
- i_wr_req  in  1  write request, level
- i_wr_cmd / i_wr_ba / i_wr_addr  in  4/BA_W/ADDR_W  write stage bus
- i_wr_data  in  DQ_W  write data
- i_wr_dq_oe  in  1  write stage DQ output enable
- i_wr_done  in  1  write complete pulse
- i_rd_req  in  1  read request, level
- i_rd_cmd / i_rd_ba / i_rd_addr  in  4/BA_W/ADDR_W  read stage bus
- i_rd_done  in  1  read complete pulse
- o_aref_en  out  1  refresh grant/start
- o_wr_en  out  1  write grant; feeds write stage start
- o_rd_en  out  1  read grant; feeds read stage start
- o_sdram_cke  out  1  clock enable
- o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n  out  1 each  command pins
- o_sdram_ba  out  BA_W  bank pins
- o_sdram_addr  out  ADDR_W  address pins
- io_sdram_dq  inout  DQ_W  data pins
- o_rd_dq  out  DQ_W  DQ input path to read stage

Clocking and reset:
- Clock i_sysclk. Reset i_sysrst_n, asynchronous, active-low.

Behaviour:
- States: INIT, ARBIT, AREF, WRITE, READ. Registered state; reset → INIT.
- INIT: stays while i_init_done=0; init_done=1 → ARBIT on the next edge.
- ARBIT transitions, evaluated each cycle:
  - aref_req → AREF.
  - else wr_req && rd_req → WRITE if r_last_wr=0, else READ.
  - else wr_req → WRITE.
  - else rd_req → READ.
  - else stay in ARBIT.
- AREF → ARBIT on i_aref_done. WRITE → ARBIT on i_wr_done. READ → ARBIT on i_rd_done.
- r_last_wr: reset 0. Set to 1 on entry to WRITE, cleared to 0 on entry to READ; unchanged by AREF.
- An active operation is never pre-empted. A refresh request during WRITE/READ waits.
- At least one ARBIT cycle separates consecutive grants. Done and a new request in the same cycle → ARBIT first, grant on the following edge.
- Enables are combinational from state only: o_aref_en=(state==AREF), o_wr_en=(state==WRITE), o_rd_en=(state==READ). Each is therefore 0 in the cycle after done, so a downstream stage returning to idle does not restart.
- Command mux, combinational from state:
  - INIT → init bus.
  - AREF → aref bus.
  - WRITE → wr bus.
  - READ → rd bus.
  - ARBIT/default → NOP 4'b0111, ba all-ones, addr all-ones.
- Pin mapping: {cs_n,ras_n,cas_n,we_n}=mux cmd.
- o_sdram_cke: 0 in reset, 1 from the first clock after reset release (registered).
- Reset values: state INIT; enables 0; command mux outputs init bus values (init stage itself emits NOP in reset); cke 0; DQ high-Z.
- DQ path:
  - io_sdram_dq = i_wr_dq_oe ? i_wr_data : high-Z.
  - Output enable is honoured in any state (write stage only asserts it while granted).
  - o_rd_dq = io_sdram_dq, combinational, no register.
- Reset mid-operation: immediate return to INIT, NOP-equivalent bus, DQ released; r_last_wr cleared.
- Done pulses received outside the matching state are ignored.

Decomposition:
- Shared package (sdram_pkg): command encodings NOP/PRECHARGE/ACTIVE/WRITE/READ/AREF/BURST_TERMINATE/LOAD_MODE, default NOP ba/addr values, BA_W/ADDR_W/DQ_W defaults.
- Arbiter state encodings stay local.
- No sub-module; the DQ tri-state stays inline.

Test Plan:
- Reset, then i_init_done=1 after 10 cycles → INIT for 10 cycles, ARBIT next, pins NOP 0111/ba 3/addr 1FFF, cke=1.
- Write request with wr_done 20 cycles later → o_wr_en high for exactly those cycles. Pins mirror i_wr_cmd, e.g. ACTIVE 0011 with ba 1/addr 0x0ABC. DQ drives i_wr_data when oe=1, else Z.
- aref_req, wr_req and rd_req all raised in ARBIT → AREF granted first. After aref_done, 1 ARBIT cycle, then WRITE (last_wr=0). After wr_done, READ (round-robin).
- aref_req raised mid-WRITE → WRITE completes uninterrupted; AREF granted 2 cycles after wr_done.
- Read with external DQ driven 0x5A5A, i_wr_dq_oe=0 → io_sdram_dq not driven by DUT, o_rd_dq=0x5A5A.
- Reset asserted in READ → state INIT immediately, enables 0, DQ Z. Stray i_rd_done in ARBIT → no state change.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {CS_N,RAS_N,CAS_N,WE_N},
// default bus widths and the idle bus values.
package sdram_pkg;

  localparam int unsigned SDRAM_BA_W   = 2;
  localparam int unsigned SDRAM_ADDR_W = 13;
  localparam int unsigned SDRAM_DQ_W   = 16;

  localparam logic [3:0] CMD_LOAD_MODE       = 4'b0000;
  localparam logic [3:0] CMD_AREF            = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE       = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE          = 4'b0011;
  localparam logic [3:0] CMD_WRITE           = 4'b0100;
  localparam logic [3:0] CMD_READ            = 4'b0101;
  localparam logic [3:0] CMD_BURST_TERMINATE = 4'b0110;
  localparam logic [3:0] CMD_NOP             = 4'b0111;

  localparam logic [SDRAM_BA_W-1:0]   NOP_BA   = '1;
  localparam logic [SDRAM_ADDR_W-1:0] NOP_ADDR = '1;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: grants the command bus to init/refresh/write/read stages,
// drives the SDRAM pins and owns the DQ tri-state buffer.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int unsigned BA_W   = SDRAM_BA_W,
  parameter int unsigned ADDR_W = SDRAM_ADDR_W,
  parameter int unsigned DQ_W   = SDRAM_DQ_W
) (
  input  logic              i_sysclk,
  input  logic              i_sysrst_n,

  input  logic [3:0]        i_init_cmd,
  input  logic [BA_W-1:0]   i_init_ba,
  input  logic [ADDR_W-1:0] i_init_addr,
  input  logic              i_init_done,

  input  logic              i_aref_req,
  input  logic [3:0]        i_aref_cmd,
  input  logic [BA_W-1:0]   i_aref_ba,
  input  logic [ADDR_W-1:0] i_aref_addr,
  input  logic              i_aref_done,

  input  logic              i_wr_req,
  input  logic [3:0]        i_wr_cmd,
  input  logic [BA_W-1:0]   i_wr_ba,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DQ_W-1:0]   i_wr_data,
  input  logic              i_wr_dq_oe,
  input  logic              i_wr_done,

  input  logic              i_rd_req,
  input  logic [3:0]        i_rd_cmd,
  input  logic [BA_W-1:0]   i_rd_ba,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_done,

  output logic              o_aref_en,
  output logic              o_wr_en,
  output logic              o_rd_en,

  output logic              o_sdram_cke,
  output logic              o_sdram_cs_n,
  output logic              o_sdram_ras_n,
  output logic              o_sdram_cas_n,
  output logic              o_sdram_we_n,
  output logic [BA_W-1:0]   o_sdram_ba,
  output logic [ADDR_W-1:0] o_sdram_addr,
  inout  wire  [DQ_W-1:0]   io_sdram_dq,
  output logic [DQ_W-1:0]   o_rd_dq
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

  state_t     state;
  logic       r_last_wr;
  logic [3:0] mux_cmd;

  // Arbiter state; every grant returns through ARBIT so grants never abut.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) begin
      state     <= ST_INIT;
      r_last_wr <= 1'b0;
    end else begin
      case (state)
        ST_INIT: if (i_init_done) state <= ST_ARBIT;
        ST_ARBIT: begin
          if (i_aref_req) begin
            state <= ST_AREF;
          end else if (i_wr_req && (!i_rd_req || !r_last_wr)) begin
            state     <= ST_WRITE;
            r_last_wr <= 1'b1;
          end else if (i_rd_req) begin
            state     <= ST_READ;
            r_last_wr <= 1'b0;
          end
        end
        ST_AREF:  if (i_aref_done) state <= ST_ARBIT;
        ST_WRITE: if (i_wr_done)   state <= ST_ARBIT;
        ST_READ:  if (i_rd_done)   state <= ST_ARBIT;
        default:  state <= ST_INIT;
      endcase
    end
  end

  // Clock enable rises on the first edge after reset release.
  always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
    if (!i_sysrst_n) o_sdram_cke <= 1'b0;
    else             o_sdram_cke <= 1'b1;
  end

  assign o_aref_en = (state == ST_AREF);
  assign o_wr_en   = (state == ST_WRITE);
  assign o_rd_en   = (state == ST_READ);

  // Command/address mux; idle bus is NOP with all-ones bank and address.
  always_comb begin
    mux_cmd      = CMD_NOP;
    o_sdram_ba   = '1;
    o_sdram_addr = '1;
    case (state)
      ST_INIT: begin
        mux_cmd      = i_init_cmd;
        o_sdram_ba   = i_init_ba;
        o_sdram_addr = i_init_addr;
      end
      ST_AREF: begin
        mux_cmd      = i_aref_cmd;
        o_sdram_ba   = i_aref_ba;
        o_sdram_addr = i_aref_addr;
      end
      ST_WRITE: begin
        mux_cmd      = i_wr_cmd;
        o_sdram_ba   = i_wr_ba;
        o_sdram_addr = i_wr_addr;
      end
      ST_READ: begin
        mux_cmd      = i_rd_cmd;
        o_sdram_ba   = i_rd_ba;
        o_sdram_addr = i_rd_addr;
      end
      default: ;
    endcase
  end

  assign {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} = mux_cmd;

  // DQ released while in reset regardless of the write stage's enable.
  assign io_sdram_dq = (i_wr_dq_oe && i_sysrst_n) ? i_wr_data : {DQ_W{1'bz}};
  assign o_rd_dq     = io_sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed self-checking bench for sdram_arbit.
module tb_sdram_arbit;
  import sdram_pkg::*;

  logic        clk, rst_n;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]  init_ba, aref_ba, wr_ba, rd_ba;
  logic [12:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        init_done, aref_req, aref_done, wr_req, wr_done, rd_req, rd_done;
  logic [15:0] wr_data;
  logic        wr_dq_oe;
  logic        aref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic [15:0] rd_dq;
  wire  [15:0] dq;
  logic        tb_dq_oe;
  logic [15:0] tb_dq;

  int checks = 0;
  int errors = 0;

  assign dq = tb_dq_oe ? tb_dq : 16'hzzzz;

  sdram_arbit dut (
    .i_sysclk(clk), .i_sysrst_n(rst_n),
    .i_init_cmd(init_cmd), .i_init_ba(init_ba), .i_init_addr(init_addr), .i_init_done(init_done),
    .i_aref_req(aref_req), .i_aref_cmd(aref_cmd), .i_aref_ba(aref_ba), .i_aref_addr(aref_addr),
    .i_aref_done(aref_done),
    .i_wr_req(wr_req), .i_wr_cmd(wr_cmd), .i_wr_ba(wr_ba), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_wr_dq_oe(wr_dq_oe), .i_wr_done(wr_done),
    .i_rd_req(rd_req), .i_rd_cmd(rd_cmd), .i_rd_ba(rd_ba), .i_rd_addr(rd_addr), .i_rd_done(rd_done),
    .o_aref_en(aref_en), .o_wr_en(wr_en), .o_rd_en(rd_en),
    .o_sdram_cke(cke), .o_sdram_cs_n(cs_n), .o_sdram_ras_n(ras_n), .o_sdram_cas_n(cas_n),
    .o_sdram_we_n(we_n), .o_sdram_ba(sd_ba), .o_sdram_addr(sd_addr),
    .io_sdram_dq(dq), .o_rd_dq(rd_dq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // {aref,wr,rd} enables plus {cmd,ba,addr} pins against expected values.
  task automatic test_reset;
    rst_n = 1'b0;
    step(3);
    checks++;
    if ({aref_en, wr_en, rd_en, cke} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got en/cke=%b want 0000", {aref_en, wr_en, rd_en, cke});
    end
    checks++;
    if ({cs_n, ras_n, cas_n, we_n, sd_ba, sd_addr} !== {CMD_PRECHARGE, 2'd2, 13'h0400}) begin
      errors++; $display("FAIL reset_bus: got %h want %h", {cs_n, ras_n, cas_n, we_n, sd_ba, sd_addr},
                         {CMD_PRECHARGE, 2'd2, 13'h0400});
    end
    tb_dq_oe = 1'b1; tb_dq = 16'h3C3C; wr_dq_oe = 1'b1; wr_data = 16'hFFFF;
    #1;
    checks++;
    if (rd_dq !== 16'h3C3C) begin
      errors++; $display("FAIL reset_dq_released: got %h want 3c3c", rd_dq);
    end
    tb_dq_oe = 1'b0; wr_dq_oe = 1'b0;
    rst_n = 1'b1;
    step(1);
    checks++;
    if (cke !== 1'b1) begin
      errors++; $display("FAIL cke_after_reset: got %b want 1", cke);
    end
  endtask

  task automatic test_init;
    int in_init = 0;
    for (int i = 0; i < 10; i++) begin
      if ({cs_n, ras_n, cas_n, we_n} == CMD_PRECHARGE && !aref_en && !wr_en && !rd_en) in_init++;
      step(1);
    end
    checks++;
    if (in_init !== 10) begin
      errors++; $display("FAIL init_hold: got %0d INIT cycles want 10", in_init);
    end
    init_done = 1'b1;
    step(1);
    checks++;
    if ({cs_n, ras_n, cas_n, we_n, sd_ba, sd_addr} !== {4'b0111, 2'd3, 13'h1FFF}) begin
      errors++; $display("FAIL arbit_nop: got %h want %h", {cs_n, ras_n, cas_n, we_n, sd_ba, sd_addr},
                         {4'b0111, 2'd3, 13'h1FFF});
    end
  endtask

  task automatic test_priority;
    aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step(1);
    checks++;
    if ({aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n} !== {3'b100, CMD_AREF}) begin
      errors++; $display("FAIL prio_aref_first: got %b want %b", {aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n},
                         {3'b100, CMD_AREF});
    end
    aref_req = 1'b0;
    step(2);
    aref_done = 1'b1;
    step(1);
    aref_done = 1'b0;
    checks++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      errors++; $display("FAIL prio_arbit_gap: got %b want 000", {aref_en, wr_en, rd_en});
    end
    step(1);
    checks++;
    if ({aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n, sd_ba, sd_addr} !==
        {3'b010, CMD_ACTIVE, 2'd1, 13'h0ABC}) begin
      errors++; $display("FAIL prio_write_first: got %h want %h",
                         {aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n, sd_ba, sd_addr},
                         {3'b010, CMD_ACTIVE, 2'd1, 13'h0ABC});
    end
    wr_req = 1'b0;
    step(1);
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;
    checks++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      errors++; $display("FAIL prio_gap_after_wr: got %b want 000", {aref_en, wr_en, rd_en});
    end
    step(1);
    checks++;
    if ({aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n, sd_ba, sd_addr} !==
        {3'b001, CMD_READ, 2'd3, 13'h0055}) begin
      errors++; $display("FAIL prio_read_rr: got %h want %h",
                         {aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n, sd_ba, sd_addr},
                         {3'b001, CMD_READ, 2'd3, 13'h0055});
    end
    rd_req = 1'b0; rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
  endtask

  task automatic test_write;
    int high = 0;
    wr_req = 1'b1;
    step(1);
    wr_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wr_en) high++;
      if (i == 5) begin
        wr_dq_oe = 1'b1; wr_data = 16'hBEEF; #1;
        checks++;
        if (rd_dq !== 16'hBEEF) begin
          errors++; $display("FAIL write_dq_drive: got %h want beef", rd_dq);
        end
        wr_dq_oe = 1'b0; tb_dq_oe = 1'b1; tb_dq = 16'h1234; #1;
        checks++;
        if (rd_dq !== 16'h1234) begin
          errors++; $display("FAIL write_dq_release: got %h want 1234", rd_dq);
        end
        tb_dq_oe = 1'b0;
      end
      if (i == 19) wr_done = 1'b1;
      step(1);
    end
    wr_done = 1'b0;
    checks++;
    if (high !== 20 || wr_en !== 1'b0) begin
      errors++; $display("FAIL write_len: got %0d cycles/en=%b want 20/0", high, wr_en);
    end
  endtask

  task automatic test_aref_during_write;
    int bad = 0;
    wr_req = 1'b1;
    step(1);
    wr_req = 1'b0; aref_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!wr_en || aref_en) bad++;
      step(1);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL aref_no_preempt: got %0d bad cycles want 0", bad);
    end
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;
    checks++;
    if ({aref_en, wr_en} !== 2'b00) begin
      errors++; $display("FAIL aref_gap: got %b want 00", {aref_en, wr_en});
    end
    step(1);
    checks++;
    if (aref_en !== 1'b1) begin
      errors++; $display("FAIL aref_after_write: got %b want 1", aref_en);
    end
    aref_req = 1'b0; aref_done = 1'b1;
    step(1);
    aref_done = 1'b0;
  endtask

  task automatic test_read_dq_and_reset;
    rd_req = 1'b1;
    step(1);
    rd_req = 1'b0;
    wr_dq_oe = 1'b0; tb_dq_oe = 1'b1; tb_dq = 16'h5A5A;
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;
    checks++;
    if ({rd_en, rd_dq} !== {1'b1, 16'h5A5A}) begin
      errors++; $display("FAIL read_dq: got en=%b dq=%h want 1/5a5a", rd_en, rd_dq);
    end
    tb_dq_oe = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({aref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n} !== {4'b0000, CMD_PRECHARGE}) begin
      errors++; $display("FAIL reset_in_read: got %b want %b", {aref_en, wr_en, rd_en, cke, cs_n, ras_n, cas_n, we_n},
                         {4'b0000, CMD_PRECHARGE});
    end
    step(1);
    rst_n = 1'b1;
    step(1);
    checks++;
    if ({cke, cs_n, ras_n, cas_n, we_n} !== {1'b1, CMD_NOP}) begin
      errors++; $display("FAIL reinit_arbit: got %b want %b", {cke, cs_n, ras_n, cas_n, we_n}, {1'b1, CMD_NOP});
    end
  endtask

  task automatic test_stray_done_and_rr_after_reset;
    rd_done = 1'b1; wr_done = 1'b1; aref_done = 1'b1;
    step(1);
    rd_done = 1'b0; wr_done = 1'b0; aref_done = 1'b0;
    step(1);
    checks++;
    if ({aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n} !== {3'b000, CMD_NOP}) begin
      errors++; $display("FAIL stray_done: got %b want %b", {aref_en, wr_en, rd_en, cs_n, ras_n, cas_n, we_n},
                         {3'b000, CMD_NOP});
    end
    wr_req = 1'b1; rd_req = 1'b1;
    step(1);
    wr_req = 1'b0;
    checks++;
    if ({wr_en, rd_en} !== 2'b10) begin
      errors++; $display("FAIL rr_after_reset: got %b want 10", {wr_en, rd_en});
    end
    wr_done = 1'b1;
    step(1);
    wr_done = 1'b0;
    step(1);
    checks++;
    if ({wr_en, rd_en} !== 2'b01) begin
      errors++; $display("FAIL rr_read_next: got %b want 01", {wr_en, rd_en});
    end
    rd_req = 1'b0; rd_done = 1'b1;
    step(1);
    rd_done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    init_cmd = CMD_PRECHARGE; init_ba = 2'd2; init_addr = 13'h0400; init_done = 1'b0;
    aref_cmd = CMD_AREF;      aref_ba = 2'd2; aref_addr = 13'h0011;
    wr_cmd   = CMD_ACTIVE;    wr_ba   = 2'd1; wr_addr   = 13'h0ABC;
    rd_cmd   = CMD_READ;      rd_ba   = 2'd3; rd_addr   = 13'h0055;
    aref_req = 1'b0; aref_done = 1'b0; wr_req = 1'b0; wr_done = 1'b0;
    rd_req = 1'b0; rd_done = 1'b0;
    wr_data = 16'h0000; wr_dq_oe = 1'b0; tb_dq_oe = 1'b0; tb_dq = 16'h0000;
    #2;
    test_reset;
    test_init;
    test_priority;
    test_write;
    test_aref_during_write;
    test_read_dq_and_reset;
    test_stray_done_and_rr_after_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
